// File: rtl/riscv_pkg.sv
// Shared types for the core and its writeback self-check monitor.
// Holds the checker FSM states and the expected-value table entry.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] xlen_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        DONE
    } wb_chk_state_t;

    // "reg" is a keyword, so the checked register field is reg_idx
    typedef struct packed {
        logic       en;
        logic [4:0] reg_idx;
        xlen_t      value;
    } check_entry_t;

endpackage

// File: rtl/riscv_shadow_regfile.sv
// Shadow copy of the architectural register file.
// One write port, one async read port, x0 reads as zero.
module riscv_shadow_regfile #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_clr,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] r_regs [32];
    logic            w_wr;

    assign w_wr = i_we && (i_waddr != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_clr) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (i_raddr == 5'd0) ? '0 : r_regs[i_raddr];

endmodule

// File: rtl/riscv_wb_checker.sv
// Writeback self-check monitor: shadows the register file during a run,
// then scans a table of expected values and reports pass/fail results.
module riscv_wb_checker #(
    parameter int XLEN           = riscv_pkg::XLEN,
    parameter int NUM_CHECKS     = 8,
    parameter int TIMEOUT_CYCLES = 200,
    localparam int CIW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int CW  = $clog2(NUM_CHECKS + 1),
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd_addr,
    input  logic [XLEN-1:0] wb_write_data,
    input  logic            halt,
    input  logic            start,
    input  logic            clear,
    input  logic            cfg_we,
    input  logic [CIW-1:0]  cfg_idx,
    input  logic            cfg_en,
    input  logic [4:0]      cfg_reg,
    input  logic [XLEN-1:0] cfg_value,
    output logic            busy,
    output logic            done,
    output logic            pass_all,
    output logic            timed_out,
    output logic [CW-1:0]   pass_count,
    output logic [CW-1:0]   fail_count,
    output logic            first_fail_valid,
    output logic [CIW-1:0]  first_fail_idx,
    output logic [TW-1:0]   cycle_count
);

    import riscv_pkg::*;

    wb_chk_state_t   r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_pass_all;
    logic            r_timed_out;
    logic [CW-1:0]   r_pass;
    logic [CW-1:0]   r_fail;
    logic            r_ff_valid;
    logic [CIW-1:0]  r_ff_idx;
    logic [TW-1:0]   r_cycle;
    logic [CIW-1:0]  r_idx;

    check_entry_t    r_table [NUM_CHECKS];
    check_entry_t    w_ent;

    logic            w_cfg_ok;
    logic            w_start;
    logic            w_tmo;
    logic            w_last;
    logic            w_match;
    logic            w_new_fail;
    logic            w_sh_we;
    logic [XLEN-1:0] w_rdata;

    assign w_start  = (r_state == IDLE) && start;
    assign w_cfg_ok = (r_state == IDLE) && cfg_we
                   && (int'(cfg_idx) < NUM_CHECKS);
    assign w_tmo    = (r_cycle == TW'(TIMEOUT_CYCLES - 1));
    assign w_last   = (r_idx == CIW'(NUM_CHECKS - 1));
    assign w_sh_we  = (r_state == RUN) && wb_reg_write;

    assign w_ent      = r_table[r_idx];
    assign w_match    = (w_rdata == XLEN'(w_ent.value));
    assign w_new_fail = w_ent.en && !w_match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CHECKS; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_cfg_ok) begin
            r_table[cfg_idx] <= '{
                en:      cfg_en,
                reg_idx: cfg_reg,
                value:   xlen_t'(cfg_value)
            };
        end
    end

    riscv_shadow_regfile #(
        .XLEN (XLEN)
    ) u_shadow (
        .clk     (clk),
        .rst_n   (reset),
        .i_clr   (w_start),
        .i_we    (w_sh_we),
        .i_waddr (wb_rd_addr),
        .i_wdata (wb_write_data),
        .i_raddr (w_ent.reg_idx),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass_all  <= 1'b0;
            r_timed_out <= 1'b0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_ff_valid  <= 1'b0;
            r_ff_idx    <= '0;
            r_cycle     <= '0;
            r_idx       <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= RUN;
                        r_busy      <= 1'b1;
                        r_timed_out <= 1'b0;
                        r_pass      <= '0;
                        r_fail      <= '0;
                        r_ff_valid  <= 1'b0;
                        r_ff_idx    <= '0;
                        r_cycle     <= '0;
                        r_idx       <= '0;
                    end
                end
                RUN: begin
                    if (halt || w_tmo) begin
                        // halt wins a tie with the timeout cycle
                        r_state     <= CHECK;
                        r_timed_out <= !halt;
                        r_idx       <= '0;
                    end else begin
                        r_cycle <= r_cycle + TW'(1);
                    end
                end
                CHECK: begin
                    if (w_ent.en) begin
                        if (w_match) begin
                            r_pass <= r_pass + CW'(1);
                        end else begin
                            r_fail <= r_fail + CW'(1);
                            if (!r_ff_valid) begin
                                r_ff_valid <= 1'b1;
                                r_ff_idx   <= r_idx;
                            end
                        end
                    end
                    if (w_last) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_pass_all <= !r_timed_out && (r_fail == '0)
                                   && !w_new_fail;
                    end else begin
                        r_idx <= r_idx + CIW'(1);
                    end
                end
                DONE: begin
                    if (clear) begin
                        r_state    <= IDLE;
                        r_done     <= 1'b0;
                        r_pass_all <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy             = r_busy;
    assign done             = r_done;
    assign pass_all         = r_pass_all;
    assign timed_out        = r_timed_out;
    assign pass_count       = r_pass;
    assign fail_count       = r_fail;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_idx   = r_ff_idx;
    assign cycle_count      = r_cycle;

endmodule

// File: tb/tb_riscv_wb_checker.sv
// Scoreboard bench for riscv_wb_checker: runs push expected results,
// a negedge monitor pops and compares them when done rises.
module tb_riscv_wb_checker;

    localparam int N   = 8;
    localparam int TMO = 200;
    localparam int CIW = 3;
    localparam int CW  = 4;
    localparam int TW  = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           wb_reg_write = 1'b0;
    logic [4:0]     wb_rd_addr = '0;
    logic [31:0]    wb_write_data = '0;
    logic           halt = 1'b0;
    logic           start = 1'b0;
    logic           clear = 1'b0;
    logic           cfg_we = 1'b0;
    logic [CIW-1:0] cfg_idx = '0;
    logic           cfg_en = 1'b0;
    logic [4:0]     cfg_reg = '0;
    logic [31:0]    cfg_value = '0;
    logic           busy;
    logic           done;
    logic           pass_all;
    logic           timed_out;
    logic [CW-1:0]  pass_count;
    logic [CW-1:0]  fail_count;
    logic           first_fail_valid;
    logic [CIW-1:0] first_fail_idx;
    logic [TW-1:0]  cycle_count;

    always #5 clk = ~clk;

    riscv_wb_checker #(
        .XLEN           (32),
        .NUM_CHECKS     (N),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .wb_reg_write     (wb_reg_write),
        .wb_rd_addr       (wb_rd_addr),
        .wb_write_data    (wb_write_data),
        .halt             (halt),
        .start            (start),
        .clear            (clear),
        .cfg_we           (cfg_we),
        .cfg_idx          (cfg_idx),
        .cfg_en           (cfg_en),
        .cfg_reg          (cfg_reg),
        .cfg_value        (cfg_value),
        .busy             (busy),
        .done             (done),
        .pass_all         (pass_all),
        .timed_out        (timed_out),
        .pass_count       (pass_count),
        .fail_count       (fail_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_idx   (first_fail_idx),
        .cycle_count      (cycle_count)
    );

    typedef struct {
        int pc;
        int fc;
        int ffv;
        int ffi;
        int to;
        int pa;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t m_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   n_run = 0;
    logic prev_done = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done && !prev_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", sb_q.size(), 1);
            end else begin
                m_e = sb_q.pop_front();
                chk("pass_count", int'(pass_count), m_e.pc);
                chk("fail_count", int'(fail_count), m_e.fc);
                chk("first_fail_valid", int'(first_fail_valid), m_e.ffv);
                chk("first_fail_idx", int'(first_fail_idx), m_e.ffi);
                chk("timed_out", int'(timed_out), m_e.to);
                chk("pass_all", int'(pass_all), m_e.pa);
                chk("cycle_count", int'(cycle_count), m_e.cyc);
                chk("busy_in_done", int'(busy), 0);
            end
        end
        prev_done = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int idx, input bit en, input int r,
                       input logic [31:0] v);
        cfg_we    = 1'b1;
        cfg_idx   = CIW'(idx);
        cfg_en    = en;
        cfg_reg   = 5'(r);
        cfg_value = v;
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_run = 0;
        chk("busy_run", int'(busy), 1);
    endtask

    task automatic cyc(input bit wr, input int a, input logic [31:0] d);
        wb_reg_write  = wr;
        wb_rd_addr    = 5'(a);
        wb_write_data = d;
        tick();
        wb_reg_write  = 1'b0;
        n_run++;
    endtask

    task automatic finish(input bit hlt, input bit wr, input int a,
                          input logic [31:0] d, input exp_t e);
        exp_t x;
        x     = e;
        x.cyc = n_run;
        sb_q.push_back(x);
        halt          = hlt;
        wb_reg_write  = wr;
        wb_rd_addr    = 5'(a);
        wb_write_data = d;
        tick();
        halt          = 1'b0;
        wb_reg_write  = 1'b0;
        repeat (N - 1) tick();
        chk("done_early", int'(done), 0);
        tick();
        chk("done_latency", int'(done), 1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clear_done", int'(done), 0);
        chk("clear_pass_all", int'(pass_all), 0);
        chk("clear_busy", int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass_all", int'(pass_all), 0);
        chk("rst_pass_count", int'(pass_count), 0);
        chk("rst_fail_count", int'(fail_count), 0);
        chk("rst_cycle_count", int'(cycle_count), 0);
        reset = 1'b1;
        tick();

        // all four entries match
        cfg(0, 1, 5, 32'd1);
        cfg(1, 1, 6, 32'd2);
        cfg(2, 1, 7, 32'd4);
        cfg(3, 1, 8, 32'd8);
        go();
        cyc(1, 5, 32'd1);
        cyc(1, 6, 32'd2);
        cyc(1, 7, 32'd4);
        cyc(1, 8, 32'd8);
        finish(1, 0, 0, 0, '{pc:4, fc:0, ffv:0, ffi:0, to:0, pa:1, cyc:0});
        do_clear();

        // x8 mismatch; cfg_we and start during RUN must be dropped
        go();
        cyc(1, 5, 32'd1);
        cfg_we    = 1'b1;
        cfg_idx   = 3'd0;
        cfg_en    = 1'b1;
        cfg_reg   = 5'd5;
        cfg_value = 32'd99;
        start     = 1'b1;
        cyc(1, 6, 32'd2);
        cfg_we    = 1'b0;
        start     = 1'b0;
        cyc(1, 7, 32'd4);
        cyc(1, 8, 32'd9);
        finish(1, 0, 0, 0, '{pc:3, fc:1, ffv:1, ffi:3, to:0, pa:0, cyc:0});
        do_clear();

        // timeout with no halt
        go();
        repeat (TMO - 1) cyc(0, 0, 0);
        finish(0, 0, 0, 0, '{pc:0, fc:4, ffv:1, ffi:0, to:1, pa:0, cyc:0});
        do_clear();

        // halt on the timeout cycle wins
        go();
        repeat (TMO - 1) cyc(0, 0, 0);
        finish(1, 0, 0, 0, '{pc:0, fc:4, ffv:1, ffi:0, to:0, pa:0, cyc:0});
        do_clear();

        // x0 writes dropped, WB on halt cycle captured, last index used
        cfg(0, 1, 0, 32'd0);
        cfg(1, 1, 18, 32'hAA);
        cfg(2, 0, 0, 32'd0);
        cfg(3, 0, 0, 32'd0);
        cfg(7, 1, 31, 32'h1234);
        go();
        cyc(1, 0, 32'hDEADBEEF);
        cyc(1, 31, 32'h1234);
        finish(1, 1, 18, 32'hAA,
               '{pc:3, fc:0, ffv:0, ffi:0, to:0, pa:1, cyc:0});
        do_clear();

        // async reset in the middle of CHECK
        go();
        cyc(1, 18, 32'hAA);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        tick();
        tick();
        chk("pre_reset_pass", int'(pass_count), 2);
        #2;
        reset = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_pass_count", int'(pass_count), 0);
        chk("abort_fail_count", int'(fail_count), 0);
        chk("abort_cycle_count", int'(cycle_count), 0);
        chk("abort_ffv", int'(first_fail_valid), 0);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // fresh run; stale table entries would now fail
        cfg(0, 1, 3, 32'd7);
        go();
        cyc(1, 3, 32'd7);
        finish(1, 0, 0, 0, '{pc:1, fc:0, ffv:0, ffi:0, to:0, pa:1, cyc:0});
        do_clear();

        tick();
        tick();
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_wb_checker.md
Name: riscv_wb_checker

Overview:
- Synthesizable self-check monitor for the pipelined core, usable in simulation and on FPGA without hierarchical peeks.
- Snoops the writeback port and keeps a shadow copy of the architectural register file.
- On halt or timeout, scans a programmable table of expected register values and reports pass/fail counts and the first failing entry.
- Sits beside riscv_pipelined_core; the bench or an FPGA top drives the config port.

Parameters:
XLEN, 32, register/data width
NUM_CHECKS, 8, number of expected-value table entries (>=1)
TIMEOUT_CYCLES, 200, RUN cycles before a forced end-of-run

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-low (asserted when 0)
wb_reg_write  in  1  writeback enable from core
wb_rd_addr  in  5  writeback destination register
wb_write_data  in  XLEN  writeback data
halt  in  1  core-finished pulse/level
start  in  1  begin run (1-cycle pulse)
clear  in  1  return DONE->IDLE
cfg_we  in  1  table write strobe
cfg_idx  in  CIW=max(1,$clog2(NUM_CHECKS))  table entry index
cfg_en  in  1  entry enabled
cfg_reg  in  5  register checked by entry
cfg_value  in  XLEN  expected value
busy  out  1  RUN or CHECK
done  out  1  DONE state
pass_all  out  1  done and fail_count==0 and !timed_out
timed_out  out  1  run ended by timeout
pass_count  out  CW=$clog2(NUM_CHECKS+1)  enabled entries matching
fail_count  out  CW  enabled entries mismatching
first_fail_valid  out  1  at least one mismatch
first_fail_idx  out  CIW  lowest failing entry index
cycle_count  out  TW=$clog2(TIMEOUT_CYCLES+1)  RUN cycles elapsed

Behaviour:
- Reset (reset==0, async): state IDLE; all outputs 0; shadow regs 0; table entries disabled.
- FSM IDLE -> RUN on start; RUN -> CHECK on halt or cycle_count==TIMEOUT_CYCLES-1; CHECK -> DONE after entry NUM_CHECKS-1 is evaluated; DONE -> IDLE on clear. start is ignored outside IDLE; clear is ignored outside DONE.
- cfg_we is accepted only in IDLE (dropped otherwise). cfg_idx >= NUM_CHECKS is ignored.
- On start: shadow regs, counters, first_fail_* and timed_out cleared; cycle_count=0.
- RUN: cycle_count increments each cycle. When wb_reg_write=1 and wb_rd_addr!=0, shadow[wb_rd_addr]<=wb_write_data; x0 writes are dropped, so shadow[0] stays 0.
- A writeback in the same cycle as halt or the timeout cycle is captured.
- timed_out=1 only if the timeout fires without halt on that cycle; halt wins a tie.
- CHECK: one entry per cycle, index 0..NUM_CHECKS-1.
  - Disabled entries are skipped, with no count change.
  - Enabled entry: match -> pass_count++; mismatch -> fail_count++, and if !first_fail_valid, record idx and set first_fail_valid.
  - Writeback inputs are ignored in CHECK.
- Latency: done rises exactly NUM_CHECKS+1 cycles after the cycle that leaves RUN. Outputs hold in DONE until clear.
- Asynchronous reset mid-RUN or mid-CHECK aborts to IDLE with everything cleared; table contents are lost.
- Counter widths fit the maximum values exactly; no wrap is possible.

Decomposition:
- riscv_pkg: add the wb_chk_state_t enum (IDLE, RUN, CHECK, DONE) and the check_entry_t struct {en, reg, value}.
- Use XLEN from the package as the parameter default.
- One sub-module: riscv_shadow_regfile (32xXLEN, one write port, one async read port, x0 hardwired to 0, synchronous clear).

Test Plan:
1. Table {x5=1, x6=2, x7=4, x8=8}; start; drive WB writes 1,2,4,8; halt -> after NUM_CHECKS+1 cycles done=1, pass_count=4, fail_count=0, pass_all=1.
2. Entry 3 expects x8=8 but WB writes x8=9 -> fail_count=1, first_fail_valid=1, first_fail_idx=3, pass_all=0.
3. No halt for 200 cycles -> timed_out=1, cycle_count=199, pass_all=0. Repeat with halt on cycle 199 -> timed_out=0.
4. WB write x0=0xDEADBEEF; entry expects x0=0 -> pass; WB in the same cycle as halt (x18=0xAA) -> entry x18=0xAA passes.
5. cfg_we and start issued during RUN -> table unchanged, FSM unaffected. clear in DONE -> IDLE with done=0.
6. reset=0 asserted mid-CHECK -> busy=0, done=0, all counters 0 immediately; a fresh config and start completes normally.
